// File: rtl/oric_ram_pkg.sv
// Shared types for the Oric RAM arbiter.
//   state_e     : access sequencer states
//   owner_e     : which requester owns the current SRAM access
//   dma_entry_t : one queued loader write {addr, data}
package oric_ram_pkg;

  localparam int unsigned DMA_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StWait,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnVid,
    OwnCpu,
    OwnDma
  } owner_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } dma_entry_t;

endpackage

// File: rtl/ram_dma_fifo.sv
// DMA write queue for the RAM arbiter (only instantiated when RAM_ARB_DMA_EN is defined).
//   clk_i, rst_ni : clock, async active-low reset (flushes the queue)
//   push_i/data_i : enqueue one entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : oldest entry
//   empty_o/full_o: occupancy flags
module ram_dma_fifo
  import oric_ram_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  dma_entry_t data_i,
  input  logic       pop_i,
  output dma_entry_t head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int unsigned   PtrW  = $clog2(DMA_FIFO_DEPTH);
  localparam logic [PtrW:0] Depth = (PtrW + 1)'(DMA_FIFO_DEPTH);

  dma_entry_t      mem_q [DMA_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == Depth);
  assign empty_o = (cnt_q == '0);
  // A push while full is refused even if the head pops in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shared SRAM arbiter: ULA video fetch, CPU access and (optional) loader DMA writes.
// Each access runs IDLE -> SETUP -> WAIT (RAM_LAT cycles) -> DONE; the ack pulses in DONE.
// Build option: define RAM_ARB_DMA_EN to include the DMA queue, starvation boost and DMA
// grant; otherwise dma_ack/dma_busy are tied low and DMA inputs are ignored.
// Ports:
//   CLK_IN, RESETn            : clock, async active-low reset
//   phi2                      : 1 = CPU slot, 0 = video slot
//   vid_req/addr, vid_ack/q   : video read port
//   cpu_req/we/addr/d, cpu_ack/q : CPU read/write port
//   dma_req/addr/d, dma_ack   : DMA write push; dma_busy = work pending or in flight
//   ram_ad/d/q, ram_cs/oe/we  : SRAM pins, active-high strobes
module ram_arbiter
  import oric_ram_pkg::*;
#(
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 255
) (
  input  logic        CLK_IN,
  input  logic        RESETn,
  input  logic        phi2,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_q,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d,
  output logic        cpu_ack,
  output logic [7:0]  cpu_q,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_d,
  output logic        dma_ack,
  output logic        dma_busy,
  output logic [15:0] ram_ad,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_we
);

  localparam logic [1:0] LatLast   = 2'(RAM_LAT - 1);
  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e      state_q, state_d;
  owner_e      owner_q, grant;
  logic [1:0]  lat_q, lat_d;
  logic        wr_q;
  logic [15:0] ad_q;
  logic [7:0]  wd_q;
  logic [7:0]  vid_data_q, cpu_data_q;
  logic        in_done, dma_pop, boost, fifo_empty;
  dma_entry_t  fifo_head;

  // Grant priority, evaluated only in IDLE.
  always_comb begin
    grant = OwnNone;
    if (!phi2 && vid_req)                grant = OwnVid;
    else if (phi2 && cpu_req && !boost)  grant = OwnCpu;
    else if (!fifo_empty)                grant = OwnDma;
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      StIdle:  if (grant != OwnNone) state_d = StSetup;
      StSetup: begin
        state_d = StWait;
        lat_d   = '0;
      end
      StWait: begin
        if (lat_q == LatLast) state_d = StDone;
        else                  lat_d   = lat_q + 2'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= StIdle;
      owner_q    <= OwnNone;
      lat_q      <= '0;
      wr_q       <= 1'b0;
      ad_q       <= '0;
      wd_q       <= '0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      // Address/data latch only on grant, so they hold through SETUP..DONE.
      if (state_q == StIdle && grant != OwnNone) begin
        owner_q <= grant;
        case (grant)
          OwnVid: begin
            ad_q <= vid_addr;
            wd_q <= '0;
            wr_q <= 1'b0;
          end
          OwnCpu: begin
            ad_q <= cpu_addr;
            wd_q <= cpu_d;
            wr_q <= cpu_we;
          end
          default: begin
            ad_q <= fifo_head.addr;
            wd_q <= fifo_head.data;
            wr_q <= 1'b1;
          end
        endcase
      end
      if (vid_ack)          vid_data_q <= ram_q;
      if (cpu_ack && !wr_q) cpu_data_q <= ram_q;
    end
  end

  assign in_done = (state_q == StDone);
  assign vid_ack = in_done & (owner_q == OwnVid);
  assign cpu_ack = in_done & (owner_q == OwnCpu);
  assign dma_pop = in_done & (owner_q == OwnDma);

  // Read data is passed through during the ack cycle and held afterwards.
  assign vid_q = vid_ack ? ram_q : vid_data_q;
  assign cpu_q = (cpu_ack && !wr_q) ? ram_q : cpu_data_q;

  assign ram_ad = ad_q;
  assign ram_d  = wd_q;
  assign ram_cs = (state_q != StIdle);
  assign ram_oe = ram_cs & ~wr_q;
  assign ram_we = wr_q & ((state_q == StSetup) | (state_q == StWait));

`ifdef RAM_ARB_DMA_EN
  logic       fifo_full;
  logic       dma_active;
  logic       dma_grant;
  logic [7:0] wait_q;
  dma_entry_t push_entry;

  assign push_entry = '{addr: dma_addr, data: dma_d};
  // Gated by RESETn so every output reads 0 while reset is held.
  assign dma_ack    = dma_req & ~fifo_full & RESETn;

  ram_dma_fifo u_dma_fifo (
    .clk_i   (CLK_IN),
    .rst_ni  (RESETn),
    .push_i  (dma_ack),
    .data_i  (push_entry),
    .pop_i   (dma_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign dma_active = (owner_q == OwnDma) & (state_q != StIdle);
  assign dma_grant  = (state_q == StIdle) & (grant == OwnDma);
  assign dma_busy   = ~fifo_empty | dma_active;
  assign boost      = (wait_q == StarveMax);

  // Starvation counter: counts cycles DMA has work queued but does not own the RAM.
  always_ff @(posedge CLK_IN or negedge RESETn) begin
    if (!RESETn) begin
      wait_q <= '0;
    end else if (dma_grant) begin
      wait_q <= '0;
    end else if (!fifo_empty && !dma_active && wait_q != StarveMax) begin
      wait_q <= wait_q + 8'd1;
    end
  end
`else
  logic unused_dma;
  assign unused_dma = ^{dma_req, dma_addr, dma_d, dma_pop, StarveMax};
  assign fifo_empty = 1'b1;
  assign fifo_head  = '0;
  assign dma_ack    = 1'b0;
  assign dma_busy   = 1'b0;
  assign boost      = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized phase, all
// compared every cycle against a transaction-level reference model (access age since grant,
// DMA queue as a SystemVerilog queue, starvation count as an integer).
module tb_ram_arbiter;

  localparam int unsigned RAM_LAT    = 1;
  localparam int unsigned STARVE_MAX = 255;
`ifdef RAM_ARB_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif
  localparam int OwnerVid = 1;
  localparam int OwnerCpu = 2;
  localparam int OwnerDma = 3;

  logic        CLK_IN;
  logic        RESETn;
  logic        phi2;
  logic        vid_req, cpu_req, cpu_we, dma_req;
  logic [15:0] vid_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_d, dma_d, ram_q;
  logic        vid_ack, cpu_ack, dma_ack, dma_busy;
  logic [7:0]  vid_q, cpu_q, ram_d;
  logic [15:0] ram_ad;
  logic        ram_cs, ram_oe, ram_we;

  ram_arbiter #(
    .RAM_LAT    (RAM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK_IN   (CLK_IN),
    .RESETn   (RESETn),
    .phi2     (phi2),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_q    (vid_q),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_d    (cpu_d),
    .cpu_ack  (cpu_ack),
    .cpu_q    (cpu_q),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_d    (dma_d),
    .dma_ack  (dma_ack),
    .dma_busy (dma_busy),
    .ram_ad   (ram_ad),
    .ram_d    (ram_d),
    .ram_q    (ram_q),
    .ram_cs   (ram_cs),
    .ram_oe   (ram_oe),
    .ram_we   (ram_we)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_busy;
  int          m_age;      // 1 = first cycle after the granting IDLE cycle
  int          m_owner;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  bit          m_wr;
  logic [23:0] m_fifo [$];
  int          m_wait;
  logic [7:0]  m_vid_q, m_cpu_q;

  // Per-cycle observations for stimulus and directed checks.
  bit          e_vid_ack, e_cpu_ack, e_done;
  bit          obs_vid_ack, obs_cpu_ack, obs_dma_ack;
  int          n_we, n_dma_wr, lat, first_acks, push_left;
  logic [15:0] we_ad;
  logic [7:0]  we_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_owner = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_wr    = 1'b0;
    m_fifo.delete();
    m_wait  = 0;
    m_vid_q = '0;
    m_cpu_q = '0;
  endtask

  task automatic start(input int owner, input logic [15:0] a, input logic [7:0] d,
                       input bit wr);
    m_busy  = 1'b1;
    m_age   = 1;
    m_owner = owner;
    m_addr  = a;
    m_wdata = d;
    m_wr    = wr;
  endtask

  task automatic check_outputs();
    bit done, eva, eca, eda, edb;
    done = m_busy && (m_age == RAM_LAT + 2);
    eva  = done && m_owner == OwnerVid;
    eca  = done && m_owner == OwnerCpu;
    eda  = DMA_EN && RESETn && dma_req && (m_fifo.size() < 4);
    edb  = DMA_EN && (m_fifo.size() != 0 || (m_busy && m_owner == OwnerDma));
    chk("vid_ack", vid_ack, eva);
    chk("cpu_ack", cpu_ack, eca);
    chk("vid_q", vid_q, eva ? ram_q : m_vid_q);
    chk("cpu_q", cpu_q, (eca && !m_wr) ? ram_q : m_cpu_q);
    chk("dma_ack", dma_ack, eda);
    chk("dma_busy", dma_busy, edb);
    chk("ram_cs", ram_cs, m_busy);
    chk("ram_oe", ram_oe, m_busy && !m_wr);
    chk("ram_we", ram_we, m_busy && m_wr && m_age <= RAM_LAT + 1);
    chk("ram_ad", ram_ad, m_addr);
    if (m_busy && m_wr) chk("ram_d", ram_d, m_wdata);
    chk("ack_excl", vid_ack & cpu_ack, 1'b0);
    e_vid_ack   = eva;
    e_cpu_ack   = eca;
    e_done      = done;
    obs_vid_ack = vid_ack;
    obs_cpu_ack = cpu_ack;
    obs_dma_ack = dma_ack;
    if (ram_we) begin
      n_we++;
      we_ad = ram_ad;
      we_d  = ram_d;
    end
    if (ram_cs && !ram_we && !ram_oe && ram_ad[15:8] == 8'h80) n_dma_wr++;
  endtask

  task automatic model_step();
    bit boost, nonempty, was_dma, dma_grant, push;
    boost     = (m_wait == STARVE_MAX);
    nonempty  = (m_fifo.size() != 0);
    was_dma   = m_busy && m_owner == OwnerDma;
    push      = DMA_EN && dma_req && (m_fifo.size() < 4);
    dma_grant = 1'b0;
    if (m_busy) begin
      if (m_age == RAM_LAT + 2) begin
        if (m_owner == OwnerVid)           m_vid_q = ram_q;
        if (m_owner == OwnerCpu && !m_wr)  m_cpu_q = ram_q;
        if (m_owner == OwnerDma)           void'(m_fifo.pop_front());
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end else if (!phi2 && vid_req) begin
      start(OwnerVid, vid_addr, 8'h00, 1'b0);
    end else if (phi2 && cpu_req && !boost) begin
      start(OwnerCpu, cpu_addr, cpu_d, cpu_we);
    end else if (DMA_EN && nonempty) begin
      start(OwnerDma, m_fifo[0][23:8], m_fifo[0][7:0], 1'b1);
      dma_grant = 1'b1;
    end
    if (dma_grant)                                            m_wait = 0;
    else if (nonempty && !was_dma && m_wait < STARVE_MAX)     m_wait++;
    if (push) m_fifo.push_back({dma_addr, dma_d});
  endtask

  // Check at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    @(negedge CLK_IN);
    check_outputs();
    if (RESETn) model_step();
    else        model_reset();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic wait_quiet();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy && m_fifo.size() == 0) break;
      tick();
    end
    chk("quiet_cs", ram_cs, 1'b0);
    chk("quiet_busy", dma_busy, 1'b0);
  endtask

  initial begin
    RESETn = 1'b1; phi2 = 1'b0; ram_q = '0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_d = '0;
    dma_req = 1'b0; dma_addr = '0; dma_d = '0;
    model_reset();
    #2;
    RESETn = 1'b0;
    #1;
    chk("rst_cs", ram_cs, 1'b0);
    chk("rst_ad", ram_ad, 16'h0000);
    chk("rst_vid_q", vid_q, 8'h00);
    chk("rst_cpu_q", cpu_q, 8'h00);
    tick();
    tick();
    RESETn = 1'b1;
    tick();

    // Video read in the video slot.
    phi2 = 1'b0; vid_req = 1'b1; vid_addr = 16'hBB80; ram_q = 8'h41; n_we = 0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_vid_ack) begin
        lat = i;
        break;
      end
    end
    vid_req = 1'b0;
    chk("vid_latency", lat, RAM_LAT + 2);
    chk("vid_q_held", vid_q, 8'h41);
    chk("vid_no_we", n_we, 0);
    tick();

    // CPU write in the CPU slot.
    phi2 = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_d = 8'h5A;
    n_we = 0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_cpu_ack) begin
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
    chk("cpu_latency", lat, RAM_LAT + 2);
    chk("cpu_we_cycles", n_we, RAM_LAT + 1);
    chk("cpu_we_ad", we_ad, 16'h0400);
    chk("cpu_we_d", we_d, 8'h5A);
    wait_quiet();

    // Five back-to-back DMA pushes while the CPU hogs its slot.
    phi2 = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000; ram_q = 8'h77;
    dma_addr = 16'h8000; dma_d = 8'h10; push_left = 5; first_acks = 0; n_dma_wr = 0;
    for (int c = 0; c < 2000; c++) begin
      dma_req = (push_left > 0);
      tick();
      if (c < 5 && obs_dma_ack) first_acks++;
      if (obs_dma_ack) begin
        push_left--;
        dma_addr = dma_addr + 16'd1;
        dma_d    = dma_d + 8'd1;
      end
      if (push_left == 0 && !dma_busy) break;
    end
    dma_req = 1'b0;
    chk("dma_first_acks", first_acks, DMA_EN ? 4 : 0);
    chk("dma_writes", n_dma_wr, DMA_EN ? 5 : 0);
    wait_quiet();

    // Randomized mix with phi2 flipping per access and occasionally mid-access.
    for (int c = 0; c < 1500; c++) begin
      ram_q = 8'($urandom);
      if (!vid_req && $urandom_range(0, 3) == 0) begin
        vid_req  = 1'b1;
        vid_addr = 16'($urandom);
      end
      if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'($urandom);
        cpu_addr = 16'($urandom);
        cpu_d    = 8'($urandom);
      end
      dma_req  = ($urandom_range(0, 3) == 0);
      dma_addr = 16'($urandom);
      dma_d    = 8'($urandom);
      tick();
      if (e_vid_ack) vid_req = 1'b0;
      if (e_cpu_ack) cpu_req = 1'b0;
      if (e_done || $urandom_range(0, 7) == 0) phi2 = ~phi2;
    end
    wait_quiet();

    // Reset in the WAIT phase of a CPU write with a DMA entry queued.
    phi2 = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2222; cpu_d = 8'hC3;
    dma_req = 1'b1; dma_addr = 16'h8123; dma_d = 8'h99;
    tick();
    dma_req = 1'b0;
    tick();
    chk("pre_rst_we", ram_we, 1'b1);
    RESETn = 1'b0;
    #1;
    chk("rst_mid_we", ram_we, 1'b0);
    chk("rst_mid_cs", ram_cs, 1'b0);
    chk("rst_mid_ack", cpu_ack, 1'b0);
    chk("rst_mid_busy", dma_busy, 1'b0);
    model_reset();
    cpu_req = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_cs", ram_cs, 1'b0);
    chk("post_rst_busy", dma_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
